// File: rtl/nes_palette_ram_pkg.sv
// Shared constants, toggle-state type and palette index mapping for nes_palette_ram.
// PALETTE_MIRROR_EN folds sprite backdrop entries $10/$14/$18/$1C onto $00/$04/$08/$0C.
package nes_palette_ram_pkg;

  localparam int         PAL_ENTRIES     = 32;
  localparam logic [5:0] PALETTE_BASE_HI = 6'h3F;
  localparam int         VADDR_W         = 14;

  typedef enum logic {HI, LO} tog_state_t;

  function automatic logic [4:0] pal_idx(input logic [4:0] a);
`ifdef PALETTE_MIRROR_EN
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
`else
    return a;
`endif
  endfunction

endpackage

// File: rtl/nes_palette_store.sv
// 32-entry palette storage: one write port, registered read port (1-cycle latency, read-before-write).
// Index mirroring follows pal_idx, so PALETTE_MIRROR_EN applies to both ports.
module nes_palette_store
  import nes_palette_ram_pkg::*;
#(
  parameter int PAL_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [PAL_W-1:0] wr_dat,
  input  logic [4:0]       rd_addr,
  output logic [7:0]       rd_dat
);

  logic [PAL_W-1:0] mem_q [PAL_ENTRIES];
  logic [7:0]       rd_d;
  logic [7:0]       rd_q;
  logic [4:0]       wr_idx;
  logic [4:0]       rd_idx;

  assign wr_idx = pal_idx(wr_addr);
  assign rd_idx = pal_idx(rd_addr);

  // Upper bits above the colour index always read as zero.
  always_comb begin
    rd_d              = '0;
    rd_d[PAL_W-1:0]   = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) mem_q[wr_idx] <= wr_dat;
      rd_q <= rd_d;
    end
  end

  assign rd_dat = rd_q;

endmodule

// File: rtl/nes_palette_ram.sv
// PPUADDR/PPUDATA decoder with two-write address latch, auto-increment and writable palette.
// Palette writes land in nes_palette_store; other PPUDATA writes pulse ext_we one cycle later.
module nes_palette_ram
  import nes_palette_ram_pkg::*;
#(
  parameter int PAL_W     = 6,
  parameter int INC_LARGE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_we,
  input  logic                reg_sel,
  input  logic [7:0]          reg_din,
  input  logic                inc32,
  input  logic                latch_clr,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_dout,
  output logic [VADDR_W-1:0]  vaddr,
  output logic                ext_we,
  output logic [7:0]          ext_din,
  output logic                lo_pend
);

  tog_state_t         state_q, state_d, state_eff;
  logic [5:0]         hi_q, hi_d;
  logic [VADDR_W-1:0] vaddr_q, vaddr_d;
  logic [VADDR_W-1:0] vstep;
  logic               ext_we_q, ext_we_d;
  logic [7:0]         ext_din_q, ext_din_d;
  logic               pal_we;

  assign vstep = inc32 ? VADDR_W'(INC_LARGE) : VADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    vaddr_d   = vaddr_q;
    ext_we_d  = 1'b0;
    ext_din_d = ext_din_q;
    pal_we    = 1'b0;
    // A PPUSTATUS read rewinds the toggle before any same-cycle PPUADDR write is decoded.
    state_eff = latch_clr ? HI : state_q;
    state_d   = state_eff;
    if (reg_we && !reg_sel) begin
      if (state_eff == HI) begin
        hi_d    = reg_din[5:0];
        state_d = LO;
      end else begin
        vaddr_d = {hi_q, reg_din};
        state_d = HI;
      end
    end else if (reg_we && reg_sel) begin
      if (vaddr_q[13:8] == PALETTE_BASE_HI) begin
        pal_we = 1'b1;
      end else begin
        ext_we_d  = 1'b1;
        ext_din_d = reg_din;
      end
      vaddr_d = vaddr_q + vstep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HI;
      hi_q      <= '0;
      vaddr_q   <= '0;
      ext_we_q  <= 1'b0;
      ext_din_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      vaddr_q   <= vaddr_d;
      ext_we_q  <= ext_we_d;
      ext_din_q <= ext_din_d;
    end
  end

  nes_palette_store #(.PAL_W(PAL_W)) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pal_we),
    .wr_addr (vaddr_q[4:0]),
    .wr_dat  (reg_din[PAL_W-1:0]),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dout)
  );

  assign vaddr   = vaddr_q;
  assign ext_we  = ext_we_q;
  assign ext_din = ext_din_q;
  assign lo_pend = (state_q == LO);

endmodule

// File: doc/nes_palette_ram.md
# nes_palette_ram

Writable NES palette memory: the CPU-side writer for the 32-entry palette the PPU pixel pipeline reads. Decodes PPUADDR/PPUDATA register writes (two-write address latch, auto-increment), stores 6-bit colour indices for $3F00–$3F1F, and serves the renderer through a synchronous read port with the same one-cycle latency as the palette ROMs it replaces. Writes outside the palette range are forwarded to the VRAM/CHR path.

## Interface
- PAL_W, 6, stored colour-index width; upper 8-PAL_W bits of read data are zero
- INC_LARGE, 32, address increment when inc32 is high (1 otherwise)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reg_we  in  1  single-cycle CPU register write strobe
- reg_sel  in  1  0 = PPUADDR ($2006), 1 = PPUDATA ($2007)
- reg_din  in  8  CPU write data
- inc32  in  1  PPUCTRL bit 2, sampled on PPUDATA writes
- latch_clr  in  1  PPUSTATUS read pulse; resets the address toggle
- rd_addr  in  5  renderer palette address
- rd_dout  out  8  palette data, registered, one cycle after rd_addr
- vaddr  out  14  current VRAM address
- ext_we  out  1  one-cycle pulse: PPUDATA write to vaddr < $3F00
- ext_din  out  8  data accompanying ext_we (address = vaddr before increment)
- lo_pend  out  1  1 while the address latch awaits the low byte

## Operation
- Toggle FSM, two states: HI (reset) and LO.
  - HI + PPUADDR write: hi_t <= reg_din[5:0]; -> LO.
  - LO + PPUADDR write: vaddr <= {hi_t, reg_din}; -> HI.
  - latch_clr: -> HI, hi_t unchanged; dominates a same-cycle PPUADDR write, which is then taken as the high byte (hi_t loaded, state stays LO after).
- PPUDATA write (either state, toggle unaffected):
  - vaddr[13:8] == 6'h3F: pal[idx(vaddr[4:0])] <= reg_din[PAL_W-1:0]; ext_we low.
  - otherwise: ext_we = 1, ext_din = reg_din for that cycle.
  - then vaddr <= (vaddr + (inc32 ? INC_LARGE : 1)) mod 2^14; wraps $3FFF -> $0000.
- Read: rd_dout <= {0, pal[idx(rd_addr)]} every cycle, no enable.
- Reset values: state HI, hi_t 0, vaddr 0, all 32 entries 0, rd_dout 0, ext_we 0, ext_din 0, lo_pend 0.

## Timing
- Register writes take effect on the clk edge where reg_we is sampled high; ext_we/ext_din are registered and valid the following cycle.
- Read latency exactly 1 cycle.
- Same-edge read/write to the same entry: rd_dout returns the old value; new value visible from the next read.
- Back-to-back PPUDATA writes every cycle supported; each increments vaddr.
- Reset asserted mid-sequence (e.g. in LO): everything returns to reset values immediately; first PPUADDR write after release is a high byte.

## Configuration
- PALETTE_MIRROR_EN defined: idx maps $10/$14/$18/$1C to $00/$04/$08/$0C on both write and read (NES hardware behaviour, 28 distinct entries).
- Undefined: idx is identity; all 32 entries independent.

## Structure
- Shared package: PAL_ENTRIES = 32, PALETTE_BASE_HI = 6'h3F, VADDR_W = 14, toggle-state enum {HI, LO}.
- One sub-module natural: nes_palette_store (32×PAL_W storage, write port, registered read port, idx mirroring); the top holds the toggle FSM, vaddr and ext forwarding.

## Test plan
- Reset, then read all rd_addr 0..31 -> rd_dout = 8'h00 each, one cycle after address.
- PPUADDR $3F,$00; PPUDATA $15,$2D,$27,$30 with inc32=0 -> rd_addr 0..3 return $15,$2D,$27,$30; vaddr = $3F04.
- With PALETTE_MIRROR_EN: write $0F to $3F10 -> rd_addr 0 and 16 both $0F; without macro: rd_addr 16 = $0F, rd_addr 0 unchanged.
- PPUADDR $20,$00, PPUDATA $AB with inc32=1 -> ext_we pulse, ext_din $AB, palette untouched, vaddr = $2020.
- PPUADDR $3F then latch_clr, then PPUADDR $21,$05 -> vaddr = $2105; lo_pend 1 after $21, 0 after $05.
- vaddr = $3FFF, PPUDATA $3C -> entry $1F = $3C, vaddr wraps to $0000; same-cycle read of $1F returns old value, next read $3C.
